// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the div_sched shared-divider block.
//   state_t      : FSM state encoding (IDLE, CALC, DONE)
//   K_DEFAULT    : default divisor/remainder width
//   iter_count() : number of restoring iterations for a given K (dividend width)
// -----------------------------------------------------------------------------
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int K_DEFAULT = 32;

    // One restoring step per dividend bit; the dividend is K+32 bits wide.
    function automatic int iter_count(input int k);
        return k + 32;
    endfunction

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division step.
//   acc      in  K+1  partial remainder before the step
//   x_msb    in  1    next dividend bit (MSB first)
//   d        in  K    divisor
//   acc_next out K+1  partial remainder after the step
//   q_bit    out 1    quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_step
    import div_pkg::*;
#(
    parameter int K = K_DEFAULT
) (
    input  logic [K:0]   acc,
    input  logic         x_msb,
    input  logic [K-1:0] d,
    output logic [K:0]   acc_next,
    output logic         q_bit
);

    // One extra bit so the shifted value never wraps before the compare.
    logic [K+1:0] shifted;
    logic [K+1:0] d_ext;

    always_comb begin
        shifted  = {acc, x_msb};
        d_ext    = {2'b00, d};
        q_bit    = (shifted >= d_ext);
        acc_next = q_bit ? (K+1)'(shifted - d_ext) : shifted[K:0];
    end

endmodule

// File: rtl/div_sched.sv
// -----------------------------------------------------------------------------
// div_sched
// One restoring divider shared by N_REQ requesters under round-robin grant.
//   clk, rst     clock, asynchronous active-high reset
//   req_valid    in  N_REQ          per-requester request
//   req_ready    out N_REQ          grant strobe (one-hot or zero, IDLE only)
//   req_x        in  N_REQ x (K+32) dividends
//   req_d        in  N_REQ x K      divisors
//   rsp_valid    out 1              result held in DONE
//   rsp_ready    in  1              consumer accept
//   rsp_id       out IDW            owner of the result
//   rsp_q        out 32             low 32 quotient bits
//   rsp_r        out K              remainder
//   rsp_dz       out 1              divide-by-zero flag
//   busy         out 1              state != IDLE
//   dbg_state_o  out state_t        current FSM state
//
// Handshakes: a transfer happens on a rising edge where valid & ready are both
// high. req_ready depends combinationally on req_valid but never the reverse;
// rsp_valid/rsp_* are registered and held unchanged until rsp_ready is seen.
// -----------------------------------------------------------------------------
module div_sched
    import div_pkg::*;
#(
    parameter  int K     = K_DEFAULT,
    parameter  int N_REQ = 2,
    localparam int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ-1:0][K+31:0]  req_x,
    input  logic [N_REQ-1:0][K-1:0]   req_d,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [IDW-1:0]            rsp_id,
    output logic [31:0]               rsp_q,
    output logic [K-1:0]              rsp_r,
    output logic                      rsp_dz,
    output logic                      busy,
    output state_t                    dbg_state_o
);

    localparam int ITER = iter_count(K);
    localparam int CW   = $clog2(K + 33);

    state_t           state_q;
    logic [IDW-1:0]   last_grant_q;   // also identifies the in-flight owner
    logic [K+31:0]    x_q;
    logic [K-1:0]     d_q;
    logic [K:0]       acc_q;
    logic [30:0]      quo_q;          // bit 31 of the quotient lives only in quo_d
    logic [CW-1:0]    cnt_q;
    logic [IDW-1:0]   rsp_id_q;
    logic [31:0]      rsp_quo_q;
    logic [K-1:0]     rsp_rem_q;
    logic             rsp_dz_q;

    logic [K:0]       acc_d;
    logic             q_bit;
    logic [31:0]      quo_d;

    logic [N_REQ-1:0] grant_oh;
    logic [IDW-1:0]   grant_idx;
    logic             grant_any;

    div_step #(.K(K)) u_step (
        .acc      (acc_q),
        .x_msb    (x_q[K+31]),
        .d        (d_q),
        .acc_next (acc_d),
        .q_bit    (q_bit)
    );

    // Higher quotient bits fall off the top; only the low 32 are kept.
    assign quo_d = {quo_q, q_bit};

    // Round-robin search starting one past the last grant.
    always_comb begin
        int             idx;
        logic [IDW-1:0] idx_sel;
        grant_oh  = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = 0;
        idx_sel   = '0;
        if (state_q == IDLE) begin
            for (int i = 0; i < N_REQ; i++) begin
                idx = int'(last_grant_q) + 1 + i;
                if (idx >= N_REQ) idx = idx - N_REQ;
                idx_sel = IDW'(idx);
                if (!grant_any && req_valid[idx_sel]) begin
                    grant_any = 1'b1;
                    grant_idx = idx_sel;
                end
            end
            if (grant_any) grant_oh[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= IDW'(N_REQ - 1);
            x_q          <= '0;
            d_q          <= '0;
            acc_q        <= '0;
            quo_q        <= '0;
            cnt_q        <= '0;
            rsp_id_q     <= '0;
            rsp_quo_q    <= '0;
            rsp_rem_q    <= '0;
            rsp_dz_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_any) begin
                        last_grant_q <= grant_idx;
                        x_q          <= req_x[grant_idx];
                        d_q          <= req_d[grant_idx];
                        acc_q        <= '0;
                        quo_q        <= '0;
                        cnt_q        <= '0;
                        if (req_d[grant_idx] == '0) begin
                            // Zero divisor: answer immediately, no iterations.
                            state_q   <= DONE;
                            rsp_id_q  <= grant_idx;
                            rsp_quo_q <= '1;
                            rsp_rem_q <= req_x[grant_idx][K-1:0];
                            rsp_dz_q  <= 1'b1;
                        end else begin
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    x_q   <= x_q << 1;
                    acc_q <= acc_d;
                    quo_q <= quo_d[30:0];
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(ITER - 1)) begin
                        state_q   <= DONE;
                        rsp_id_q  <= last_grant_q;
                        rsp_quo_q <= quo_d;
                        rsp_rem_q <= acc_d[K-1:0];
                        rsp_dz_q  <= 1'b0;
                    end
                end
                DONE: begin
                    if (rsp_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready   = grant_oh;
    assign rsp_valid   = (state_q == DONE);
    assign busy        = (state_q != IDLE);
    assign rsp_id      = rsp_id_q;
    assign rsp_q       = rsp_quo_q;
    assign rsp_r       = rsp_rem_q;
    assign rsp_dz      = rsp_dz_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_div_sched.sv
// -----------------------------------------------------------------------------
// tb_div_sched
// Directed and randomized stimulus for div_sched (K=32, N_REQ=2). Expected
// results come from plain 64-bit division and a round-robin pick function.
// -----------------------------------------------------------------------------
module tb_div_sched;
    import div_pkg::*;

    localparam int K    = 32;
    localparam int ITER = 64;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0][63:0]  req_x;
    logic [1:0][31:0]  req_d;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [0:0]        rsp_id;
    logic [31:0]       rsp_q;
    logic [31:0]       rsp_r;
    logic              rsp_dz;
    logic              busy;
    state_t            dbg_state;

    div_sched #(.K(K), .N_REQ(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_x       (req_x),
        .req_d       (req_d),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_q       (rsp_q),
        .rsp_r       (rsp_r),
        .rsp_dz      (rsp_dz),
        .busy        (busy),
        .dbg_state_o (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int          checks = 0;
    int          errors = 0;
    int          model_last;
    logic [65:0] exp_q[$];   // {id, dz, q, r}

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input int last, input logic [1:0] v);
        for (int i = 1; i <= 2; i++) begin
            int c;
            c = (last + i) % 2;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [65:0] model(input int id, input logic [63:0] x, input logic [31:0] d);
        logic [63:0] qf;
        logic [63:0] rf;
        logic        idb;
        idb = id[0];
        if (d == 32'd0) return {idb, 1'b1, 32'hFFFF_FFFF, x[31:0]};
        qf = x / {32'd0, d};
        rf = x % {32'd0, d};
        return {idb, 1'b0, qf[31:0], rf[31:0]};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst       = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        model_last = 1;
        exp_q.delete();
    endtask

    // Called at posedge+1 with req_valid already driven; returns at the
    // acceptance edge +1.
    task automatic wait_grant(output int gid);
        int         tries;
        int         p;
        logic [1:0] exp_oh;
        tries = 0;
        @(negedge clk);
        while (req_ready == 2'b00 && tries < 10) begin
            @(posedge clk);
            @(negedge clk);
            tries++;
        end
        p      = rr_pick(model_last, req_valid);
        exp_oh = (p < 0) ? 2'b00 : 2'(2'b01 << p);
        chk("grant_onehot", req_ready, exp_oh);
        chk("grant_delay", tries, 0);
        chk("idle_busy", busy, 1'b0);
        gid = p;
        @(posedge clk);
        if (p >= 0) model_last = p;
        #1;
    endtask

    task automatic wait_rsp(output int lat, output int bad);
        lat = 0;
        bad = 0;
        forever begin
            @(negedge clk);
            if (rsp_valid) break;
            if (req_ready != 2'b00 || !busy) bad++;
            if (lat >= 200) break;
            @(posedge clk);
            lat++;
        end
    endtask

    task automatic finish_rsp(input int stall);
        logic [65:0] e;
        logic [65:0] snap;
        int          sbad;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 66'd0;
        chk("rsp_valid", rsp_valid, 1'b1);
        chk("rsp_id", rsp_id, e[65]);
        chk("rsp_dz", rsp_dz, e[64]);
        chk("rsp_q", rsp_q, e[63:32]);
        chk("rsp_r", rsp_r, e[31:0]);
        chk("done_ready", req_ready, 2'b00);
        snap = {rsp_id, rsp_dz, rsp_q, rsp_r};
        sbad = 0;
        repeat (stall) begin
            @(posedge clk);
            @(negedge clk);
            if (!rsp_valid || !busy || req_ready != 2'b00 ||
                {rsp_id, rsp_dz, rsp_q, rsp_r} !== snap) sbad++;
        end
        if (stall > 0) chk("stall_stable", sbad, 0);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        chk("post_hs_valid", rsp_valid, 1'b0);
        chk("post_hs_busy", busy, 1'b0);
    endtask

    task automatic run_op(input logic [1:0] mask, input logic [63:0] x0, input logic [31:0] d0,
                          input logic [63:0] x1, input logic [31:0] d1, input int stall);
        int          gid;
        int          lat;
        int          bad;
        logic [63:0] xs;
        logic [31:0] ds;
        req_x[0]  = x0;
        req_d[0]  = d0;
        req_x[1]  = x1;
        req_d[1]  = d1;
        req_valid = mask;
        wait_grant(gid);
        if (gid == 1) begin xs = x1; ds = d1; end
        else          begin xs = x0; ds = d0; end
        exp_q.push_back(model(gid, xs, ds));
        if (gid >= 0) req_valid[gid] = 1'b0;   // the loser keeps asking
        wait_rsp(lat, bad);
        chk("latency", lat, (ds == 32'd0) ? 0 : ITER);
        chk("calc_quiet", bad, 0);
        finish_rsp(stall);
    endtask

    function automatic logic [63:0] rand_x();
        if ($urandom_range(0, 3) == 0) return 64'($urandom_range(0, 1000));
        return {$urandom(), $urandom()};
    endfunction

    function automatic logic [31:0] rand_d();
        int s;
        s = $urandom_range(0, 7);
        if (s == 0) return 32'd0;
        if (s <= 2) return 32'($urandom_range(1, 20));
        return $urandom();
    endfunction

    // ---------------- directed + random sequence ----------------
    initial begin
        int gid;
        int lat;
        int bad;
        int n;

        rst        = 1'b1;
        req_valid  = 2'b00;
        rsp_ready  = 1'b0;
        req_x      = '0;
        req_d      = '0;
        model_last = 1;

        // Reset values
        @(posedge clk);
        @(negedge clk);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rsp_q", rsp_q, 32'd0);
        chk("rst_rsp_r", rsp_r, 32'd0);
        chk("rst_rsp_id", rsp_id, 1'b0);
        chk("rst_rsp_dz", rsp_dz, 1'b0);
        chk("rst_req_ready", req_ready, 2'b00);
        chk("rst_state", dbg_state, IDLE);
        @(posedge clk);
        #1 rst = 1'b0;

        // Basic division, accepted in the first cycle after reset
        run_op(2'b01, 64'd100, 32'd7, 64'd0, 32'd0, 0);
        // Divide by zero
        run_op(2'b01, 64'h0000_0000_1234_5678, 32'd0, 64'd0, 32'd0, 0);
        // Truncated quotient and large divisor
        run_op(2'b10, 64'd0, 32'd0, 64'h0000_0100_0000_0000, 32'd1, 0);
        run_op(2'b01, 64'h0000_0001_0000_0005, 32'hFFFF_FFFF, 64'd0, 32'd0, 0);
        // Response stalled for 10 cycles with the other requester waiting
        run_op(2'b11, 64'd1000, 32'd9, 64'd55, 32'd5, 10);

        // Both requesters valid continuously from reset: grants alternate
        do_reset();
        req_x[0]  = rand_x();
        req_d[0]  = rand_d();
        req_x[1]  = rand_x();
        req_d[1]  = rand_d();
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            logic [63:0] xs;
            logic [31:0] ds;
            wait_grant(gid);
            chk("rr_alternate", gid, k % 2);
            xs = (gid == 1) ? req_x[1] : req_x[0];
            ds = (gid == 1) ? req_d[1] : req_d[0];
            exp_q.push_back(model(gid, xs, ds));
            if (gid >= 0) begin
                req_x[gid] = rand_x();
                req_d[gid] = rand_d();
            end
            wait_rsp(lat, bad);
            chk("rr_latency", lat, (ds == 32'd0) ? 0 : ITER);
            chk("rr_quiet", bad, 0);
            finish_rsp(0);
        end
        req_valid = 2'b00;

        // Randomized operations
        for (int k = 0; k < 24; k++) begin
            run_op(2'($urandom_range(1, 3)), rand_x(), rand_d(), rand_x(), rand_d(),
                   $urandom_range(0, 3));
        end

        // Reset in the middle of CALC aborts the operation silently
        do_reset();
        req_x[1]  = 64'd123456789;
        req_d[1]  = 32'd11;
        req_valid = 2'b10;
        wait_grant(gid);
        req_valid = 2'b00;
        repeat (20) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_valid", rsp_valid, 1'b0);
        chk("abort_busy", busy, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_last = 1;
        exp_q.delete();
        n = 0;
        repeat (80) begin
            @(negedge clk);
            if (rsp_valid || busy) n++;
        end
        chk("abort_silent", n, 0);
        @(posedge clk);
        #1;
        run_op(2'b11, 64'd100, 32'd7, 64'd500, 32'd3, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_sched.md
DIV_SCHED -- requirements
Module: div_sched

Interface
REQ-001 Parameter K, default 32: divisor and remainder width; dividend width is K+32.
REQ-002 Parameter N_REQ, default 2: number of requesters sharing the divider.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 req_valid  input  N_REQ  per-requester request valid.
REQ-006 req_ready  output  N_REQ  per-requester accept strobe; at most one bit high per cycle.
REQ-007 req_x  input  N_REQ x (K+32)  per-requester dividend.
REQ-008 req_d  input  N_REQ x K  per-requester divisor.
REQ-009 rsp_valid  output  1  result valid.
REQ-010 rsp_ready  input  1  consumer accepts result.
REQ-011 rsp_id  output  clog2(N_REQ) (min 1)  index of the requester that owns the result.
REQ-012 rsp_q  output  32  quotient.
REQ-013 rsp_r  output  K  remainder.
REQ-014 rsp_dz  output  1  divide-by-zero flag.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 FSM states: IDLE, CALC, DONE; one operation in flight.
REQ-017 IDLE: req_ready is combinational, asserted only for the granted requester when any req_valid bit is high.
REQ-018 Grant is round-robin: search starts at (last_grant+1) mod N_REQ.
REQ-019 Acceptance edge (req_valid & req_ready) captures x, d and the requester index, and updates last_grant.
REQ-020 After acceptance with d != 0, go to CALC for exactly K+32 cycles, one restoring step per cycle, MSB of x first.
REQ-021 Restoring step: acc (K+1 bits) = (acc<<1)|next x bit; q <<= 1; if acc >= d then acc -= d and q |= 1.
REQ-022 Results: rsp_q = low 32 bits of floor(x/d), with higher quotient bits discarded; rsp_r = x mod d.
REQ-023 rsp_valid rises exactly K+32 cycles after the acceptance edge, i.e. 64 cycles for K=32.
REQ-024 d == 0: skip CALC and enter DONE on the edge after acceptance with rsp_q = all ones, rsp_r = low K bits of x, rsp_dz = 1.
REQ-025 For d != 0, rsp_dz = 0.
REQ-026 DONE: rsp_valid high; rsp_id, rsp_q, rsp_r and rsp_dz stay stable until the handshake.
REQ-027 On the rsp_valid & rsp_ready edge, go to IDLE; no request is accepted in that same cycle.
REQ-028 req_ready is 0 in CALC and DONE.
REQ-029 A requester that drops req_valid before being granted loses nothing; no grant is issued to a requester whose req_valid is low.
REQ-030 Outputs other than busy, rsp_* and req_ready are not defined.

Reset
REQ-031 rst forces IDLE, last_grant = N_REQ-1 (so requester 0 wins first), rsp_valid = 0, rsp_q = 0, rsp_r = 0, rsp_id = 0, rsp_dz = 0, busy = 0, iteration counter = 0.
REQ-032 Reset during CALC or DONE aborts the operation silently; no response is ever produced for it.
REQ-033 After rst deasserts, the first request can be accepted in the first cycle.

Structure
REQ-034 Shared package div_pkg holds the FSM state enum, the default K, and the iteration count constant K+32 as a function of K.
REQ-035 Sub-module div_step (combinational, one restoring step: acc, x_msb, d in; acc_next, q_bit out) is instantiated once inside div_sched.
REQ-036 The iteration counter is sized clog2(K+33).

Verification
REQ-037 K=32; req0 x=100, d=7 -> exactly one req_ready pulse; rsp_valid 64 cycles later with q=14, r=2, id=0, dz=0.
REQ-038 req0 and req1 both valid continuously from reset -> grants alternate 0,1,0,1; each response has the matching rsp_id.
REQ-039 x=0x12345678, d=0 -> rsp_valid on the next cycle with q=0xFFFFFFFF, r=0x12345678, dz=1.
REQ-040 x=2^40, d=1 -> q=0 (truncated), r=0; x=2^32+5, d=2^32-1 -> q=1, r=6.
REQ-041 rsp_ready held low for 10 cycles in DONE -> outputs stable, req_ready stays 0 throughout, then IDLE after the handshake.
REQ-042 rst pulsed at CALC iteration 20 -> rsp_valid and busy go to 0 immediately, no response emitted, and the next request behaves as in REQ-037.
